// File: rtl/sr_drv_pkg.sv
// sr_drv_pkg: shared types and helpers for the SR latch driver.
//   state_t    - FSM state (IDLE, PULSE, SETTLE, CHECK)
//   ST_*       - explicit state encodings
//   cnt_width  - width of the phase counter, sized for the longest phase
package sr_drv_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PULSE  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_CHECK  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        PULSE  = ST_PULSE,
        SETTLE = ST_SETTLE,
        CHECK  = ST_CHECK
    } state_t;

    // Counter holds values up to max(pulse, settle) and never wraps.
    function automatic int cnt_width(input int pulse, input int settle);
        int m;
        m = (pulse > settle) ? pulse : settle;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// sr_drv_if: request/status bundle between control logic and the latch driver.
//   req_valid, req_value : request from the controller
//   req_ready, busy      : driver availability
//   done, err            : one-cycle completion pulse and readback error
// Modports: master = controller side, slave = driver side.
interface sr_drv_if;
    logic req_valid;
    logic req_value;
    logic req_ready;
    logic busy;
    logic done;
    logic err;

    modport master (output req_valid, req_value, input req_ready, busy, done, err);
    modport slave  (input req_valid, req_value, output req_ready, busy, done, err);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: multi-flop synchronizer for the 2-bit latch feedback {q, qn}.
//   clk, rst_n : clock and async active-low reset (flops clear to 0)
//   din        : asynchronous input
//   dout       : synchronized output, STAGES clocks of latency
module sync_2ff #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] din,
    output logic [1:0] dout
);
    logic [STAGES-1:0][1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[STAGES-2:0], din};
    end

    assign dout = pipe[STAGES-1];
endmodule

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives an active-low NAND SR latch with a timed set/reset
// pulse, waits for the feedback synchronizer to flush, then reports done/err.
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : req_valid/req_value in; req_ready/busy/done/err out
//   s_n, r_n     : registered active-low set/reset to the latch, never both low
//   q_fb, qn_fb  : raw latch outputs, asynchronous to clk
// Optional: define SR_DRV_SKIP_EN to skip the pulse when the latch already
// holds the requested value (done one cycle after accept, err=0).
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 1,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    sr_drv_if.slave     bus,
    output logic        s_n,
    output logic        r_n,
    input  logic        q_fb,
    input  logic        qn_fb
);
    localparam int WAIT_CYCLES = SETTLE_CYCLES + SYNC_STAGES;
    localparam int CNT_W       = cnt_width(PULSE_CYCLES, WAIT_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             value;
    logic             ready_q;
    logic             done_q;
    logic             err_q;
    logic             q_s;
    logic             qn_s;
    logic             skip;

    // FSM only ever sees the synchronized feedback.
    sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({q_fb, qn_fb}),
        .dout  ({q_s, qn_s})
    );

`ifdef SR_DRV_SKIP_EN
    assign skip = (q_s == bus.req_value) && (qn_s == ~bus.req_value);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Async reset releases any active pulse immediately.
            state   <= IDLE;
            cnt     <= '0;
            value   <= 1'b0;
            s_n     <= 1'b1;
            r_n     <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        value   <= bus.req_value;
                        ready_q <= 1'b0;
                        if (skip) begin
                            state  <= CHECK;
                            done_q <= 1'b1;
                        end else begin
                            state <= PULSE;
                            cnt   <= CNT_W'(PULSE_CYCLES);
                            s_n   <= ~bus.req_value;
                            r_n   <= bus.req_value;
                        end
                    end
                end
                PULSE: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= SETTLE;
                        cnt   <= CNT_W'(WAIT_CYCLES);
                        s_n   <= 1'b1;
                        r_n   <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    // done/err are registered, so they are raised on the edge
                    // that enters CHECK and are visible for the CHECK cycle.
                    if (cnt == CNT_W'(1)) begin
                        state  <= CHECK;
                        cnt    <= '0;
                        done_q <= 1'b1;
                        err_q  <= (q_s != value) | (q_s == qn_s);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CHECK: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    s_n     <= 1'b1;
                    r_n     <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = ~ready_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_sr_latch_driver.sv
// tb_sr_latch_driver: directed bench for sr_latch_driver with a behavioural
// NAND SR latch on s_n/r_n -> q_fb/qn_fb. Honours SR_DRV_SKIP_EN if defined.
module tb_sr_latch_driver;
    logic clk = 1'b0;
    logic rst_n;
    logic s_n, r_n, q_fb, qn_fb;
    logic latch_q = 1'b0;
    logic frc = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sr_drv_if bus_if ();

    sr_latch_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave),
        .s_n   (s_n),
        .r_n   (r_n),
        .q_fb  (q_fb),
        .qn_fb (qn_fb)
    );

    // Behavioural latch: set dominates only because both-low never happens.
    always @(s_n or r_n) begin
        if (s_n === 1'b0)      latch_q = 1'b1;
        else if (r_n === 1'b0) latch_q = 1'b0;
    end
    assign q_fb  = frc ? 1'b1 : latch_q;
    assign qn_fb = frc ? 1'b1 : ~latch_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("never_both_low", 32'(s_n | r_n), 1);
        if (bus_if.done !== 1'b1) chk("err_without_done", 32'(bus_if.err), 0);
    end

    // One request: lat = cycle (after t0) where done is expected.
    task automatic run_req(input string tag, input logic v, input int lat,
                           input logic exp_err, input logic ps, input logic pr,
                           input logic force_settle);
        chk({tag, "_ready"}, 32'(bus_if.req_ready), 1);
        bus_if.req_value = v;
        bus_if.req_valid = 1'b1;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (force_settle && k == 3) frc = 1'b1;
            chk($sformatf("%s_s_n_c%0d", tag, k), 32'(s_n), 32'(!(ps && k <= 2)));
            chk($sformatf("%s_r_n_c%0d", tag, k), 32'(r_n), 32'(!(pr && k <= 2)));
            chk($sformatf("%s_done_c%0d", tag, k), 32'(bus_if.done), 32'(k == lat));
            if (k == lat) chk({tag, "_err"}, 32'(bus_if.err), 32'(exp_err));
        end
        frc = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_done_clear"}, 32'(bus_if.done), 0);
        chk({tag, "_idle_again"}, 32'(bus_if.req_ready), 1);
        chk({tag, "_latch_q"}, 32'(latch_q), 32'(v));
    endtask

    initial begin
        int acc[$];
        bus_if.req_valid = 1'b0;
        bus_if.req_value = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_n", 32'(s_n), 1);
        chk("rst_r_n", 32'(r_n), 1);
        chk("rst_ready", 32'(bus_if.req_ready), 1);
        chk("rst_busy", 32'(bus_if.busy), 0);
        chk("rst_done", 32'(bus_if.done), 0);
        chk("rst_err", 32'(bus_if.err), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the middle of a set pulse.
        bus_if.req_value = 1'b1;
        bus_if.req_valid = 1'b1;
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        chk("mid_s_low", 32'(s_n), 0);
        chk("mid_busy", 32'(bus_if.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_s_n", 32'(s_n), 1);
        chk("mid_rst_r_n", 32'(r_n), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 chk("mid_no_done", 32'(bus_if.done), 0);
        end
        chk("mid_ready", 32'(bus_if.req_ready), 1);

        // latch q=1 after the aborted pulse
        run_req("rst0", 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b0);
        run_req("set1", 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SR_DRV_SKIP_EN
        run_req("skip", 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        run_req("noskip", 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        run_req("forced", 1'b0, 6, 1'b1, 1'b0, 1'b1, 1'b1);

        // Back-to-back: req_valid held high, value toggled so nothing skips.
        bus_if.req_value = 1'b1;
        bus_if.req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_if.req_ready) begin
                acc.push_back(i);
                @(posedge clk);
                #1 bus_if.req_value = ~bus_if.req_value;
            end
        end
        bus_if.req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc.size() >= 3), 1);
        if (acc.size() >= 3) begin
            chk("b2b_gap0", 32'(acc[1] - acc[0]), 7);
            chk("b2b_gap1", 32'(acc[2] - acc[1]), 7);
        end
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
